enemy_wave: RTL and testbench
=============================

// Module: enemy_wave
// PURPOSE
// - Multi-slot falling-enemy engine for the VGA game.
// - Replaces the single-enemy mover with NUM_ENEMIES independent slots.
// - Adds: parametrised step tick, fall speed, periodic spawning, paddle collision, score/lives, game state.
// - Sits between the player/paddle logic and the pixel renderer; the renderer consumes the packed coordinates and active flags.
// PARAMETERS
// - NUM_ENEMIES     4       number of enemy slots
// - COORD_W         16      coordinate width, pixels
// - TICK_DIV        700000  clk cycles per movement step (simulation uses 4)
// - SPAWN_TICKS     40      steps between spawn attempts
// - ENEMY_SIZE      20      enemy square side, pixels
// - PADDLE_W        50      paddle width, pixels
// - PADDLE_H        10      paddle height, pixels
// - SPAWN_Y         80      y of a freshly spawned enemy
// - FLOOR_Y         474     enemy top y at/after which it is a miss
// - START_LIVES     3       lives loaded at game start
// PORTS
// - clk           in   1                    system clock
// - reset         in   1                    synchronous, active-high reset
// - start         in   1                    level; begins/restarts a game
// - speed         in   4                    pixels moved per step; 0 = frozen
// - spawn_x       in   COORD_W              x captured into a slot at spawn
// - x_paddle      in   COORD_W              paddle left edge
// - y_paddle      in   COORD_W              paddle top edge
// - x_enemy       out  NUM_ENEMIES*COORD_W  packed x; slot i at [i*COORD_W +: COORD_W]
// - y_enemy       out  NUM_ENEMIES*COORD_W  packed y, same packing
// - enemy_on      out  NUM_ENEMIES          per-slot active flag
// - hit_pulse     out  1                    1-cycle pulse on a step with >=1 catch
// - miss_pulse    out  1                    1-cycle pulse on a step with >=1 miss
// - score         out  16                   caught enemies, saturates at 16'hFFFF
// - lives         out  2                    remaining lives
// - game_over     out  1                    high while in state OVER
// BEHAVIOUR
// - Reset:
//   - all outputs 0, except lives = START_LIVES and y_enemy = SPAWN_Y per slot;
//   - state IDLE; tick and spawn counters 0.
// - FSM:
//   - IDLE -> PLAY when start = 1; on entry clear score, reload lives, clear enemy_on.
//   - PLAY -> OVER on the cycle lives becomes 0.
//   - OVER -> PLAY on a start rising edge (same reload as IDLE -> PLAY).
//   - reset from any state -> IDLE at the next clk edge; any step in progress is discarded.
// - Tick: free-running counter 0..TICK_DIV-1, counting only in PLAY; step = 1-cycle strobe at wrap.
// - Each step, all updates are registered together, 1 clk after the strobe:
//   - Move: active slot ny = y + speed, computed at COORD_W+1 bits (no wrap).
//   - Catch: axis-aligned overlap of enemy box [x, x+ENEMY_SIZE) x [ny, ny+ENEMY_SIZE) with paddle box [x_paddle, x_paddle+PADDLE_W) x [y_paddle, y_paddle+PADDLE_H).
//     - Edges touching is no overlap.
//     - Catch -> slot cleared, score += 1 (saturating).
//   - Miss: no catch and (ny >= FLOOR_Y or carry) -> slot cleared, y := SPAWN_Y, lives -= 1 (floor 0).
//   - Catch and miss in the same step on the same slot: catch wins.
//   - Several slots in one step: score += number of catches; lives -= number of misses; both clamp; pulses asserted once.
//   - Spawn: spawn counter counts steps.
//     - At SPAWN_TICKS-1, the lowest-index inactive slot loads x = spawn_x, y = SPAWN_Y, on = 1.
//     - If all slots are active, the spawn is dropped and the counter still wraps.
//     - A slot freed in this step is not refilled until the next spawn.
// - OVER: enemies frozen and visible, no tick, pulses 0.
// - Cleared slots keep their last x; y returns to SPAWN_Y.
// STRUCTURE
// - game_pkg holds:
//   - the state enum {IDLE, PLAY, OVER};
//   - screen constants (FLOOR_Y, SPAWN_Y);
//   - a function aabb_overlap(ax, ay, aw, ah, bx, by, bw, bh).
// - Sub-module enemy_tick_gen(clk, reset, en, tick): parametrised divider, 1-cycle strobe.
// - Slot update is a generate loop; the catch/miss popcount and priority spawn encoder are combinational.
// TESTING (TICK_DIV=4, SPAWN_TICKS=2, defaults otherwise)
// - Reset, then start=1, speed=1, spawn_x=100:
//   - enemy_on=0001 after 2 steps at (100,80);
//   - y_enemy[0]=81 one step later.
// - Paddle (90,440), enemy falls speed=4:
//   - first step where ny+20>440 clears slot 0;
//   - score=1, hit_pulse 1 cycle, lives=3.
// - Paddle at x=300, enemy at x=100:
//   - enemy reaches ny>=474 -> miss_pulse, lives=2, slot cleared, y=80.
// - Four slots active, spawn due:
//   - no change to enemy_on, spawn counter wraps;
//   - two simultaneous misses -> lives drops by 2 in one step.
// - lives=1, miss occurs:
//   - lives=0, game_over=1, positions frozen;
//   - start rising edge -> lives=3, score=0, enemy_on=0.
// - Assert reset mid-game with score=5:
//   - next edge -> score=0, lives=3, enemy_on=0, state IDLE.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : game_pkg
//  Purpose  : Shared game state encoding, screen constants and the box
//             overlap helper used by the enemy wave engine.
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Game-level state machine encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  // Screen geometry: a fresh enemy appears at SPAWN_Y and is lost once its
  // top edge reaches FLOOR_Y
  localparam int SCREEN_SPAWN_Y = 80;
  localparam int SCREEN_FLOOR_Y = 474;

  // Half-open axis-aligned box overlap; boxes that only share an edge do not
  // overlap. Arguments are wide enough that x + w never wraps.
  function automatic logic aabb_overlap(
    input logic [31:0] ax, input logic [31:0] ay,
    input logic [31:0] aw, input logic [31:0] ah,
    input logic [31:0] bx, input logic [31:0] by,
    input logic [31:0] bw, input logic [31:0] bh
  );
    return (ax < bx + bw) && (bx < ax + aw) &&
           (ay < by + bh) && (by < ay + ah);
  endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/enemy_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_tick_gen
//  Purpose  : Movement step divider. Counts 0..TICK_DIV-1 while enabled and
//             emits a registered single-cycle strobe at each wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module enemy_tick_gen #(
  parameter int TICK_DIV = 700000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter; holds its value while disabled, strobe follows the wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule : enemy_tick_gen
`default_nettype wire

// File: rtl/enemy_wave.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_wave
//  Purpose  : Multi-slot falling-enemy engine: stepped movement, periodic
//             spawning, paddle catches, floor misses, score, lives and the
//             IDLE/PLAY/OVER game state.
//  Revision : 1.0 - initial release
// ============================================================================
module enemy_wave
  import game_pkg::*;
#(
  parameter int NUM_ENEMIES = 4,
  parameter int COORD_W     = 16,
  parameter int TICK_DIV    = 700000,
  parameter int SPAWN_TICKS = 40,
  parameter int ENEMY_SIZE  = 20,
  parameter int PADDLE_W    = 50,
  parameter int PADDLE_H    = 10,
  parameter int SPAWN_Y     = SCREEN_SPAWN_Y,
  parameter int FLOOR_Y     = SCREEN_FLOOR_Y,
  parameter int START_LIVES = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [3:0]                     speed,
  input  logic [COORD_W-1:0]             spawn_x,
  input  logic [COORD_W-1:0]             x_paddle,
  input  logic [COORD_W-1:0]             y_paddle,
  output logic [NUM_ENEMIES*COORD_W-1:0] x_enemy,
  output logic [NUM_ENEMIES*COORD_W-1:0] y_enemy,
  output logic [NUM_ENEMIES-1:0]         enemy_on,
  output logic                           hit_pulse,
  output logic                           miss_pulse,
  output logic [15:0]                    score,
  output logic [1:0]                     lives,
  output logic                           game_over
);

  localparam int                 SP_W       = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
  localparam int                 CNT_W      = $clog2(NUM_ENEMIES + 1);
  localparam logic [SP_W-1:0]    SPAWN_LAST = SP_W'(SPAWN_TICKS - 1);
  localparam logic [COORD_W-1:0] SPAWN_Y_C  = COORD_W'(SPAWN_Y);
  localparam logic [COORD_W:0]   FLOOR_Y_C  = (COORD_W + 1)'(FLOOR_Y);
  localparam logic [1:0]         LIVES_INIT = 2'(START_LIVES);

  game_state_t            state, state_nx;
  logic                   tick, step, start_q, enter_play;
  logic                   spawn_due, found;
  logic [SP_W-1:0]        spawn_cnt;
  logic [NUM_ENEMIES-1:0] catch_v, miss_v, spawn_sel;
  logic [COORD_W:0]       ny [NUM_ENEMIES];
  logic [CNT_W-1:0]       n_catch, n_miss;
  logic [16:0]            score_sum;
  logic [15:0]            score_nx;
  logic [1:0]             lives_nx;

  enemy_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == PLAY),
    .tick  (tick)
  );

  // A strobe that lands after the game left PLAY is ignored
  assign step      = tick && (state == PLAY);
  assign spawn_due = (spawn_cnt == SPAWN_LAST);
  assign game_over = (state == OVER);

  // Per-slot movement, catch/miss detection and position registers
  for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_slot
    logic [COORD_W-1:0] x_q, y_q;
    logic               on_q;

    // Extra top bit keeps the carry so a wrap reads as past the floor
    assign ny[i]      = {1'b0, y_q} + (COORD_W + 1)'(speed);
    assign catch_v[i] = on_q && aabb_overlap(32'(x_q), 32'(ny[i]),
                                             32'(ENEMY_SIZE), 32'(ENEMY_SIZE),
                                             32'(x_paddle), 32'(y_paddle),
                                             32'(PADDLE_W), 32'(PADDLE_H));
    assign miss_v[i]  = on_q && !catch_v[i] &&
                        ((ny[i] >= FLOOR_Y_C) || ny[i][COORD_W]);

    assign x_enemy[i*COORD_W +: COORD_W] = x_q;
    assign y_enemy[i*COORD_W +: COORD_W] = y_q;
    assign enemy_on[i]                   = on_q;

    // Slot state: spawn load, clear on catch/miss, otherwise fall by speed
    always_ff @(posedge clk) begin
      if (reset) begin
        x_q  <= '0;
        y_q  <= SPAWN_Y_C;
        on_q <= 1'b0;
      end else if (enter_play) begin
        y_q  <= SPAWN_Y_C;
        on_q <= 1'b0;
      end else if (step) begin
        if (spawn_sel[i]) begin
          x_q  <= spawn_x;
          y_q  <= SPAWN_Y_C;
          on_q <= 1'b1;
        end else if (catch_v[i] || miss_v[i]) begin
          y_q  <= SPAWN_Y_C;
          on_q <= 1'b0;
        end else if (on_q) begin
          y_q <= ny[i][COORD_W-1:0];
        end
      end
    end
  end : g_slot

  // Lowest-index free slot wins the spawn; judged on occupancy before this
  // step's clears so a freed slot waits for the next spawn
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    if (spawn_due) begin
      for (int k = 0; k < NUM_ENEMIES; k++) begin
        if (!found && !enemy_on[k]) begin
          spawn_sel[k] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

  // Count catches and misses across all slots, then clamp score and lives
  always_comb begin
    n_catch = '0;
    n_miss  = '0;
    for (int k = 0; k < NUM_ENEMIES; k++) begin
      n_catch = n_catch + CNT_W'(catch_v[k]);
      n_miss  = n_miss  + CNT_W'(miss_v[k]);
    end
    score_sum = {1'b0, score} + 17'(n_catch);
    score_nx  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    if (int'(n_miss) >= int'(lives)) begin
      lives_nx = 2'd0;
    end else begin
      lives_nx = lives - 2'(n_miss);
    end
  end

  // Spawn counter advances once per step and wraps whether or not a slot
  // was available
  always_ff @(posedge clk) begin
    if (reset) begin
      spawn_cnt <= '0;
    end else if (step) begin
      spawn_cnt <= spawn_due ? '0 : spawn_cnt + SP_W'(1);
    end
  end

  // Game state register plus start edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start;
    end
  end

  // Next-state logic; entering PLAY reloads score, lives and slots
  always_comb begin
    state_nx   = state;
    enter_play = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = PLAY;
          enter_play = 1'b1;
        end
      end
      PLAY: begin
        if (step && (lives_nx == 2'd0)) begin
          state_nx = OVER;
        end
      end
      OVER: begin
        if (start && !start_q) begin
          state_nx   = PLAY;
          enter_play = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Score, lives and event pulses, all updated on the same edge as the slots
  always_ff @(posedge clk) begin
    if (reset) begin
      score      <= '0;
      lives      <= LIVES_INIT;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_pulse  <= step && (|catch_v);
      miss_pulse <= step && (|miss_v);
      if (enter_play) begin
        score <= '0;
        lives <= LIVES_INIT;
      end else if (step) begin
        score <= score_nx;
        lives <= lives_nx;
      end
    end
  end

endmodule : enemy_wave
`default_nettype wire

// File: tb/tb_enemy_wave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enemy_wave
//  Purpose  : Directed self-checking bench for enemy_wave with a fast step
//             divider (TICK_DIV=4) and short spawn period (SPAWN_TICKS=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_wave;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  speed;
  logic [15:0] spawn_x, x_paddle, y_paddle;
  logic [63:0] x_enemy, y_enemy;
  logic [3:0]  enemy_on;
  logic        hit_pulse, miss_pulse, game_over;
  logic [15:0] score;
  logic [1:0]  lives;

  int cyc     = 0;
  int t0      = 0;
  int vectors = 0;
  int errors  = 0;

  enemy_wave #(
    .TICK_DIV    (4),
    .SPAWN_TICKS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .speed      (speed),
    .spawn_x    (spawn_x),
    .x_paddle   (x_paddle),
    .y_paddle   (y_paddle),
    .x_enemy    (x_enemy),
    .y_enemy    (y_enemy),
    .enemy_on   (enemy_on),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Edge counter used to land checks on a specific posedge after t0
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] xe(input int i);
    return x_enemy[i*16 +: 16];
  endfunction

  function automatic logic [15:0] ye(input int i);
    return y_enemy[i*16 +: 16];
  endfunction

  // Park on the negedge following posedge number n counted from t0
  task automatic at_edge(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] exp_y;
    exp_y = {4{16'd80}};
    reset = 1'b1; start = 1'b0; speed = 4'd0; spawn_x = 16'd0;
    x_paddle = 16'd300; y_paddle = 16'd440;
    repeat (3) @(negedge clk);
    vectors++; if (lives !== 2'd3) begin $display("FAIL reset_lives got=%0d exp=3", lives); errors++; end
    vectors++; if (score !== 16'd0) begin $display("FAIL reset_score got=%0d exp=0", score); errors++; end
    vectors++; if (enemy_on !== 4'b0000) begin $display("FAIL reset_on got=%b exp=0000", enemy_on); errors++; end
    vectors++; if (y_enemy !== exp_y) begin $display("FAIL reset_y got=%h exp=%h", y_enemy, exp_y); errors++; end
    vectors++; if (x_enemy !== 64'd0) begin $display("FAIL reset_x got=%h exp=0", x_enemy); errors++; end
    vectors++; if ({game_over, hit_pulse, miss_pulse} !== 3'b000) begin
      $display("FAIL reset_flags got=%b exp=000", {game_over, hit_pulse, miss_pulse}); errors++; end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Game 1: first spawn lands on step 2 (edge 10), steps every 4 edges
  task automatic test_spawn();
    start = 1'b1; speed = 4'd1; spawn_x = 16'd100; t0 = cyc;
    at_edge(9);
    vectors++; if (enemy_on !== 4'b0000) begin $display("FAIL spawn_early got=%b exp=0000", enemy_on); errors++; end
    at_edge(10);
    vectors++; if (enemy_on !== 4'b0001) begin $display("FAIL spawn_on got=%b exp=0001", enemy_on); errors++; end
    vectors++; if (xe(0) !== 16'd100 || ye(0) !== 16'd80) begin
      $display("FAIL spawn_pos got=(%0d,%0d) exp=(100,80)", xe(0), ye(0)); errors++; end
    at_edge(14);
    vectors++; if (ye(0) !== 16'd81) begin $display("FAIL move_y got=%0d exp=81", ye(0)); errors++; end
    speed = 4'd4; x_paddle = 16'd90; y_paddle = 16'd440;
  endtask

  // Slot 0 reaches ny=421 on step 88 (edge 354); slots 1..3 fill meanwhile
  task automatic test_catch();
    at_edge(353);
    vectors++; if (hit_pulse !== 1'b0 || score !== 16'd0) begin
      $display("FAIL catch_early hit=%b score=%0d exp hit=0 score=0", hit_pulse, score); errors++; end
    at_edge(354);
    vectors++; if (hit_pulse !== 1'b1) begin $display("FAIL catch_pulse got=%b exp=1", hit_pulse); errors++; end
    vectors++; if (score !== 16'd1 || lives !== 2'd3) begin
      $display("FAIL catch_score score=%0d lives=%0d exp 1/3", score, lives); errors++; end
    vectors++; if (enemy_on !== 4'b1110) begin $display("FAIL catch_on got=%b exp=1110", enemy_on); errors++; end
    vectors++; if (ye(0) !== 16'd80 || ye(1) !== 16'd416) begin
      $display("FAIL catch_y y0=%0d y1=%0d exp 80/416", ye(0), ye(1)); errors++; end
    x_paddle = 16'd300; speed = 4'd15;
    at_edge(355);
    vectors++; if (hit_pulse !== 1'b0) begin $display("FAIL catch_width got=%b exp=0", hit_pulse); errors++; end
  endtask

  // Step 92: slot 1 misses while all four are on (spawn dropped);
  // step 93: slots 2 and 3 miss together, lives 2 -> 0
  task automatic test_miss();
    at_edge(370);
    vectors++; if (miss_pulse !== 1'b1 || lives !== 2'd2) begin
      $display("FAIL miss_single pulse=%b lives=%0d exp 1/2", miss_pulse, lives); errors++; end
    vectors++; if (enemy_on !== 4'b1101) begin $display("FAIL miss_on got=%b exp=1101", enemy_on); errors++; end
    vectors++; if (ye(1) !== 16'd80 || ye(0) !== 16'd110) begin
      $display("FAIL miss_y y1=%0d y0=%0d exp 80/110", ye(1), ye(0)); errors++; end
    at_edge(374);
    vectors++; if (lives !== 2'd0 || game_over !== 1'b1) begin
      $display("FAIL miss_double lives=%0d over=%b exp 0/1", lives, game_over); errors++; end
    vectors++; if (enemy_on !== 4'b0001 || ye(2) !== 16'd80 || ye(3) !== 16'd80 || ye(0) !== 16'd125) begin
      $display("FAIL miss_double_slots on=%b y0=%0d y2=%0d y3=%0d exp 0001/125/80/80",
               enemy_on, ye(0), ye(2), ye(3)); errors++; end
    at_edge(390);
    vectors++; if (ye(0) !== 16'd125 || enemy_on !== 4'b0001 || miss_pulse !== 1'b0 || game_over !== 1'b1) begin
      $display("FAIL over_frozen y0=%0d on=%b miss=%b over=%b exp 125/0001/0/1",
               ye(0), enemy_on, miss_pulse, game_over); errors++; end
  endtask

  task automatic test_restart();
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (game_over !== 1'b1) begin $display("FAIL restart_hold got=%b exp=1", game_over); errors++; end
    start = 1'b1; x_paddle = 16'd90;
    @(negedge clk);
    vectors++; if (game_over !== 1'b0 || lives !== 2'd3 || score !== 16'd0 || enemy_on !== 4'b0000) begin
      $display("FAIL restart over=%b lives=%0d score=%0d on=%b exp 0/3/0/0000",
               game_over, lives, score, enemy_on); errors++; end
    start = 1'b0;
  endtask

  // Let the paddle catch five enemies, then reset mid-game
  task automatic test_reset_mid();
    int n = 0;
    while (score !== 16'd5 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    vectors++; if (score !== 16'd5) begin $display("FAIL score_run got=%0d exp=5", score); errors++; end
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (score !== 16'd0 || lives !== 2'd3 || enemy_on !== 4'b0000 || game_over !== 1'b0) begin
      $display("FAIL reset_mid score=%0d lives=%0d on=%b over=%b exp 0/3/0000/0",
               score, lives, enemy_on, game_over); errors++; end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    vectors++; if (enemy_on !== 4'b0000 || score !== 16'd0) begin
      $display("FAIL idle_hold on=%b score=%0d exp 0000/0", enemy_on, score); errors++; end
  endtask

  // Game 3 at speed 15: misses on steps 29, 31, 33 (edges 118, 126, 134)
  task automatic test_last_life();
    spawn_x = 16'd200; x_paddle = 16'd300; speed = 4'd15; start = 1'b1; t0 = cyc;
    at_edge(118);
    vectors++; if (lives !== 2'd2 || enemy_on !== 4'b1110 || ye(0) !== 16'd80) begin
      $display("FAIL life_first lives=%0d on=%b y0=%0d exp 2/1110/80", lives, enemy_on, ye(0)); errors++; end
    at_edge(133);
    vectors++; if (lives !== 2'd1 || game_over !== 1'b0 || enemy_on !== 4'b1111) begin
      $display("FAIL life_one lives=%0d over=%b on=%b exp 1/0/1111", lives, game_over, enemy_on); errors++; end
    at_edge(134);
    vectors++; if (lives !== 2'd0 || game_over !== 1'b1 || enemy_on !== 4'b1011) begin
      $display("FAIL life_zero lives=%0d over=%b on=%b exp 0/1/1011", lives, game_over, enemy_on); errors++; end
    vectors++; if (ye(0) !== 16'd125 || ye(1) !== 16'd95 || ye(3) !== 16'd455 || xe(0) !== 16'd200) begin
      $display("FAIL life_pos y0=%0d y1=%0d y3=%0d x0=%0d exp 125/95/455/200",
               ye(0), ye(1), ye(3), xe(0)); errors++; end
    at_edge(150);
    vectors++; if (ye(0) !== 16'd125 || ye(3) !== 16'd455 || miss_pulse !== 1'b0 || game_over !== 1'b1) begin
      $display("FAIL life_frozen y0=%0d y3=%0d miss=%b over=%b exp 125/455/0/1",
               ye(0), ye(3), miss_pulse, game_over); errors++; end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_catch();
    test_miss();
    test_restart();
    test_reset_mid();
    test_last_life();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_enemy_wave
`default_nettype wire
